// File: rtl/rgb_to_yuv_encoder.sv
// RGB frame in SRAM -> Y/U/V planes in SRAM, 4-pixel groups, U/V decimated 2:1 (optional 3-tap filter under CHROMA_FILTER_EN).
// Latency: 12-cycle group period; group g is written in period g+1, Stop rises 12*groups+11 cycles after Start.
// Backpressure: none; the block owns the SRAM port while running and Start is ignored outside IDLE.
module rgb_to_yuv_encoder #(
    parameter int Y_START    = 0,
    parameter int U_START    = 38400,
    parameter int V_START    = 57600,
    parameter int RGB_START  = 146944,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Stop,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam int          GROUPS     = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam logic [17:0] LAST_GROUP = 18'(GROUPS - 1);
    localparam logic [17:0] Y_BASE     = 18'(Y_START);
    localparam logic [17:0] U_BASE     = 18'(U_START);
    localparam logic [17:0] V_BASE     = 18'(V_START);
    localparam logic [17:0] RGB_BASE   = 18'(RGB_START);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         phase;
    logic [17:0]        rd_group, rd_addr, wr_group;
    logic               have_prev;
    logic               busy, do_read, do_capture, do_snap, do_write;
    logic [2:0]         cap_idx;
    logic [1:0]         wr_sel;
    logic [15:0]        rgb_word [6];
    logic [15:0]        wr_word [4];
    logic [7:0]         y_res [4];
    logic [7:0]         u_res [4];
    logic [7:0]         v_res [4];
    logic [1:0]         cpx, cch;
    logic [7:0]         pix_r, pix_g, pix_b;
    logic signed [31:0] coef_r, coef_g, coef_b, offset;
    logic signed [31:0] prod_r, prod_g, prod_b, sum;
    logic [7:0]         conv_res;
    logic [7:0]         u_out0, u_out2, v_out0, v_out2;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Reads show in cycles 1..6 of a period, writes of the previous group in 7..10.
    always_comb begin
        state_next = state;
        busy       = (state == RUN) || (state == FLUSH);
        do_read    = (state == RUN) && (phase <= 4'd5);
        do_capture = (state == RUN) && (phase >= 4'd3) && (phase <= 4'd8);
        do_snap    = busy && have_prev && (phase == 4'd5);
        do_write   = busy && have_prev && (phase >= 4'd6) && (phase <= 4'd9);
        cap_idx    = 3'(phase - 4'd3);
        wr_sel     = phase[1:0] - 2'd2;
        unique case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (phase == 4'd11 && rd_group == LAST_GROUP) state_next = FLUSH;
            FLUSH:   if (phase == 4'd9) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One channel of one pixel per cycle; pixels 2/3 finish early in the following period.
    always_comb begin
        cpx = 2'd0;
        cch = 2'd0;
        case (phase)
            4'd5:  begin cpx = 2'd0; cch = 2'd0; end
            4'd6:  begin cpx = 2'd0; cch = 2'd1; end
            4'd7:  begin cpx = 2'd0; cch = 2'd2; end
            4'd8:  begin cpx = 2'd1; cch = 2'd0; end
            4'd9:  begin cpx = 2'd1; cch = 2'd1; end
            4'd10: begin cpx = 2'd1; cch = 2'd2; end
            4'd11: begin cpx = 2'd2; cch = 2'd0; end
            4'd0:  begin cpx = 2'd2; cch = 2'd1; end
            4'd1:  begin cpx = 2'd2; cch = 2'd2; end
            4'd2:  begin cpx = 2'd3; cch = 2'd0; end
            4'd3:  begin cpx = 2'd3; cch = 2'd1; end
            4'd4:  begin cpx = 2'd3; cch = 2'd2; end
            default: begin cpx = 2'd0; cch = 2'd0; end
        endcase
    end

    always_comb begin
        case (cpx)
            2'd0:    {pix_r, pix_g, pix_b} = {rgb_word[0], rgb_word[1][15:8]};
            2'd1:    {pix_r, pix_g, pix_b} = {rgb_word[1][7:0], rgb_word[2]};
            2'd2:    {pix_r, pix_g, pix_b} = {rgb_word[3], rgb_word[4][15:8]};
            default: {pix_r, pix_g, pix_b} = {rgb_word[4][7:0], rgb_word[5]};
        endcase
        case (cch)
            2'd0: begin
                coef_r = 32'sd16843;  coef_g = 32'sd33030;  coef_b = 32'sd6423;
                offset = 32'sd1081344;
            end
            2'd1: begin
                coef_r = -32'sd9699;  coef_g = -32'sd19071; coef_b = 32'sd28770;
                offset = 32'sd8421376;
            end
            default: begin
                coef_r = 32'sd28770;  coef_g = -32'sd24117; coef_b = -32'sd4653;
                offset = 32'sd8421376;
            end
        endcase
        prod_r = $signed({24'd0, pix_r}) * coef_r;
        prod_g = $signed({24'd0, pix_g}) * coef_g;
        prod_b = $signed({24'd0, pix_b}) * coef_b;
        sum    = prod_r + prod_g + prod_b + offset;
        if (sum[31])             conv_res = 8'd0;
        else if (|sum[30:24])    conv_res = 8'hFF;
        else                     conv_res = sum[23:16];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                y_res[i] <= '0;
                u_res[i] <= '0;
                v_res[i] <= '0;
            end
        end else if (busy) begin
            case (cch)
                2'd0:    y_res[cpx] <= conv_res;
                2'd1:    u_res[cpx] <= conv_res;
                default: v_res[cpx] <= conv_res;
            endcase
        end
    end

`ifdef CHROMA_FILTER_EN
    localparam logic [17:0] LAST_COL = 18'(IMG_WIDTH / 4 - 1);
    logic [7:0]  hist_u, hist_v, left_u, left_v;
    logic [17:0] wr_col;

    // At a row start the left neighbour is clamped to the group's own pixel 0.
    always_comb begin
        left_u = (wr_col == '0) ? u_res[0] : hist_u;
        left_v = (wr_col == '0) ? v_res[0] : hist_v;
        u_out0 = 8'(({2'b00, left_u} + {1'b0, u_res[0], 1'b0} + {2'b00, u_res[1]} + 10'd2) >> 2);
        u_out2 = 8'(({2'b00, u_res[1]} + {1'b0, u_res[2], 1'b0} + {2'b00, u_res[3]} + 10'd2) >> 2);
        v_out0 = 8'(({2'b00, left_v} + {1'b0, v_res[0], 1'b0} + {2'b00, v_res[1]} + 10'd2) >> 2);
        v_out2 = 8'(({2'b00, v_res[1]} + {1'b0, v_res[2], 1'b0} + {2'b00, v_res[3]} + 10'd2) >> 2);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hist_u <= '0;
            hist_v <= '0;
            wr_col <= '0;
        end else if (state == IDLE && Start) begin
            wr_col <= '0;
        end else begin
            if (do_snap) begin
                hist_u <= u_res[3];
                hist_v <= v_res[3];
            end
            if (do_write && phase == 4'd9)
                wr_col <= (wr_col == LAST_COL) ? '0 : wr_col + 18'd1;
        end
    end
`else
    always_comb begin
        u_out0 = u_res[0];
        u_out2 = u_res[2];
        v_out0 = v_res[0];
        v_out2 = v_res[2];
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Stop            <= 1'b0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            phase           <= '0;
            rd_group        <= '0;
            rd_addr         <= RGB_BASE;
            wr_group        <= '0;
            have_prev       <= 1'b0;
            for (int i = 0; i < 6; i++) rgb_word[i] <= '0;
            for (int i = 0; i < 4; i++) wr_word[i] <= '0;
        end else begin
            SRAM_we_n <= 1'b1;
            if (state == IDLE && Start) begin
                Stop      <= 1'b0;
                phase     <= '0;
                rd_group  <= '0;
                rd_addr   <= RGB_BASE;
                wr_group  <= '0;
                have_prev <= 1'b0;
            end
            if (state == DONE) Stop <= 1'b1;
            if (busy) phase <= (phase == 4'd11) ? 4'd0 : phase + 4'd1;
            if (state == RUN && phase == 4'd11) begin
                have_prev <= 1'b1;
                rd_group  <= rd_group + 18'd1;
            end
            if (do_read) begin
                SRAM_address <= rd_addr;
                rd_addr      <= rd_addr + 18'd1;
            end
            if (do_write) begin
                SRAM_we_n       <= 1'b0;
                SRAM_write_data <= wr_word[wr_sel];
                case (phase)
                    4'd6:    SRAM_address <= Y_BASE + {wr_group[16:0], 1'b0};
                    4'd7:    SRAM_address <= Y_BASE + {wr_group[16:0], 1'b1};
                    4'd8:    SRAM_address <= U_BASE + wr_group;
                    default: begin
                        SRAM_address <= V_BASE + wr_group;
                        wr_group     <= wr_group + 18'd1;
                    end
                endcase
            end
            if (do_capture) rgb_word[cap_idx] <= SRAM_read_data;
            // Freeze the finished group before the next group's pixel 0 overwrites the results.
            if (do_snap) begin
                wr_word[0] <= {y_res[0], y_res[1]};
                wr_word[1] <= {y_res[2], y_res[3]};
                wr_word[2] <= {u_out0, u_out2};
                wr_word[3] <= {v_out0, v_out2};
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Randomized and directed frames through an SRAM model, checked against a plain-arithmetic YUV reference.
module tb_rgb_to_yuv_encoder;

    localparam int W    = 8;
    localparam int H    = 3;
    localparam int G    = W * H / 4;
    localparam int NPIX = W * H;
    localparam int YS   = 0;
    localparam int US   = 38400;
    localparam int VS   = 57600;
    localparam int RS   = 146944;
    localparam int BUDGET = 12 * G + 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stop;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    logic [15:0] mem [0:262143];
    logic [15:0] rd_d1;
    int          wr_count = 0;
    int          stray = 0;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  pr [NPIX];
    logic [7:0]  pg [NPIX];
    logic [7:0]  pb [NPIX];

    always #5 Clock = ~Clock;

    rgb_to_yuv_encoder #(
        .Y_START(YS), .U_START(US), .V_START(VS), .RGB_START(RS),
        .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Stop(Stop),
        .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n),
        .SRAM_read_data(SRAM_read_data)
    );

    function automatic bit in_plane(int a);
        return (a >= YS && a < YS + 2 * G) || (a >= US && a < US + G) || (a >= VS && a < VS + G);
    endfunction

    always @(posedge Clock) begin
        rd_d1          <= mem[SRAM_address];
        SRAM_read_data <= rd_d1;
        if (SRAM_we_n == 1'b0) begin
            mem[SRAM_address] <= SRAM_write_data;
            wr_count <= wr_count + 1;
            if (!in_plane(int'(SRAM_address))) stray <= stray + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int conv(int r, int g, int b, int ch);
        int s;
        if (ch == 0)      s = 16843 * r + 33030 * g + 6423 * b + 32768 + (16 << 16);
        else if (ch == 1) s = -9699 * r - 19071 * g + 28770 * b + 32768 + (128 << 16);
        else              s = 28770 * r - 24117 * g - 4653 * b + 32768 + (128 << 16);
        s = s >>> 16;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int pix_c(int i, int ch);
        return conv(int'(pr[i]), int'(pg[i]), int'(pb[i]), ch);
    endfunction

    function automatic int chroma(int i, int ch);
        int left;
        left = (i % W == 0) ? i : i - 1;
`ifdef CHROMA_FILTER_EN
        return (pix_c(left, ch) + 2 * pix_c(i, ch) + pix_c(i + 1, ch) + 2) >> 2;
`else
        return pix_c(i, ch);
`endif
    endfunction

    // kind: 0 black, 1 white, 2 red, 3 black/blue alternating, other random
    task automatic load(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0: begin pr[i] = 8'd0;   pg[i] = 8'd0;   pb[i] = 8'd0;   end
                1: begin pr[i] = 8'd255; pg[i] = 8'd255; pb[i] = 8'd255; end
                2: begin pr[i] = 8'd255; pg[i] = 8'd0;   pb[i] = 8'd0;   end
                3: begin pr[i] = 8'd0;   pg[i] = 8'd0;   pb[i] = (i % 2 == 1) ? 8'd255 : 8'd0; end
                default: begin
                    pr[i] = 8'($urandom_range(0, 255));
                    pg[i] = 8'($urandom_range(0, 255));
                    pb[i] = 8'($urandom_range(0, 255));
                end
            endcase
        end
        for (int g = 0; g < G; g++) begin
            mem[RS + 6 * g + 0] = {pr[4 * g],     pg[4 * g]};
            mem[RS + 6 * g + 1] = {pb[4 * g],     pr[4 * g + 1]};
            mem[RS + 6 * g + 2] = {pg[4 * g + 1], pb[4 * g + 1]};
            mem[RS + 6 * g + 3] = {pr[4 * g + 2], pg[4 * g + 2]};
            mem[RS + 6 * g + 4] = {pb[4 * g + 2], pr[4 * g + 3]};
            mem[RS + 6 * g + 5] = {pg[4 * g + 3], pb[4 * g + 3]};
            mem[YS + 2 * g]     = 16'hDEAD;
            mem[YS + 2 * g + 1] = 16'hDEAD;
            mem[US + g]         = 16'hDEAD;
            mem[VS + g]         = 16'hDEAD;
        end
    endtask

    task automatic check_frame(input string tag);
        for (int g = 0; g < G; g++) begin
            int i;
            i = 4 * g;
            chk($sformatf("%s_y01_g%0d", tag, g), 32'(mem[YS + 2 * g]),
                32'({8'(pix_c(i, 0)), 8'(pix_c(i + 1, 0))}));
            chk($sformatf("%s_y23_g%0d", tag, g), 32'(mem[YS + 2 * g + 1]),
                32'({8'(pix_c(i + 2, 0)), 8'(pix_c(i + 3, 0))}));
            chk($sformatf("%s_u_g%0d", tag, g), 32'(mem[US + g]),
                32'({8'(chroma(i, 1)), 8'(chroma(i + 2, 1))}));
            chk($sformatf("%s_v_g%0d", tag, g), 32'(mem[VS + g]),
                32'({8'(chroma(i, 2)), 8'(chroma(i + 2, 2))}));
        end
    endtask

    task automatic wait_stop(input string tag, input int w0, input int s0);
        int cyc;
        cyc = 0;
        while (!Stop && cyc < BUDGET + 40) begin
            @(negedge Clock);
            cyc++;
        end
        chk({tag, "_stop"}, 32'(Stop), 32'd1);
        chk({tag, "_in_budget"}, 32'(cyc <= BUDGET), 32'd1);
        chk({tag, "_writes"}, 32'(wr_count - w0), 32'(4 * G));
        chk({tag, "_stray"}, 32'(stray - s0), 32'd0);
        check_frame(tag);
    endtask

    task automatic run_frame(input string tag);
        int w0, s0;
        w0 = wr_count;
        s0 = stray;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_stop(tag, w0, s0);
    endtask

    initial begin
        int w0, s0, cyc;
        bit hit;
        Reset = 1'b1;
        Start = 1'b0;
        #1;
        chk("rst_stop", 32'(Stop), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_addr", 32'(SRAM_address), 32'd0);
        chk("rst_wdata", 32'(SRAM_write_data), 32'd0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        load(0); run_frame("black");
        chk("black_y_const", 32'(mem[YS]), 32'h1010);
        chk("black_u_const", 32'(mem[US]), 32'h8080);
        chk("black_v_const", 32'(mem[VS + G - 1]), 32'h8080);

        load(1); run_frame("white");
        chk("white_y_const", 32'(mem[YS + 2 * G - 1]), 32'hEBEB);
        chk("white_u_const", 32'(mem[US + 1]), 32'h8080);

        load(2); run_frame("red");
        chk("red_y_const", 32'(mem[YS + 3]), 32'h5252);
        chk("red_u_const", 32'(mem[US + 2]), 32'h5A5A);
        chk("red_v_const", 32'(mem[VS]), 32'hF0F0);

        load(3); run_frame("blue_alt");
        chk("alt_y_const", 32'(mem[YS + 1]), 32'h1029);
`ifdef CHROMA_FILTER_EN
        chk("alt_u_row0", 32'(mem[US]), 32'h9CB8);
        chk("alt_u_mid",  32'(mem[US + 1]), 32'hB8B8);
        chk("alt_u_row1", 32'(mem[US + 2]), 32'h9CB8);
        chk("alt_v_row0", 32'(mem[VS]), 32'h7C77);
        chk("alt_v_mid",  32'(mem[VS + 1]), 32'h7777);
`else
        chk("alt_u_dec", 32'(mem[US]), 32'h8080);
        chk("alt_v_dec", 32'(mem[VS + 1]), 32'h8080);
`endif

        load(4); run_frame("rand0");
        load(4); run_frame("rand1");

        // Reset in the middle of a write burst, then a clean re-encode.
        load(4);
        w0 = wr_count;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge Clock);
            if (SRAM_we_n == 1'b0 && wr_count - w0 >= 12) hit = 1'b1;
        end
        chk("midrst_reached", 32'(hit), 32'd1);
        Reset = 1'b1;
        #1;
        chk("midrst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("midrst_stop", 32'(Stop), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        load(4); run_frame("after_rst");

        // Start held through completion starts a second frame; toggling during RUN is ignored.
        load(4);
        w0 = wr_count;
        s0 = stray;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        cyc = 0;
        while (!Stop && cyc < BUDGET + 40) begin
            @(negedge Clock);
            cyc++;
        end
        chk("held1_stop", 32'(Stop), 32'd1);
        chk("held1_writes", 32'(wr_count - w0), 32'(4 * G));
        check_frame("held1");
        load(4);
        w0 = wr_count;
        s0 = stray;
        @(negedge Clock);
        chk("held_stop_drop", 32'(Stop), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            Start = ~Start;
        end
        Start = 1'b0;
        wait_stop("held2", w0, s0);
        w0 = wr_count;
        repeat (30) @(negedge Clock);
        chk("held_stop_kept", 32'(Stop), 32'd1);
        chk("held_no_extra", 32'(wr_count - w0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
